// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch unit. It issues one-at-a-time fetch requests to memory,
//   buffers the returned words with their PCs in a circular queue, and presents
//   the queue head to the decoder. A jump (redirect) flushes the queue, retargets
//   the fetch PC and discards any response that is still in flight.
//
// Ports
//   clk_in          : clock, all state updates on the rising edge
//   rst_in          : synchronous active-high reset
//   mem_req_valid   : one-cycle fetch request pulse (registered)
//   mem_req_addr    : fetch address, meaningful while mem_req_valid=1
//   mem_resp_valid  : instruction word returned this cycle
//   mem_resp_data   : returned instruction word
//   jump_valid      : redirect / flush request
//   jump_pc         : redirect target
//   inst_valid      : queue head holds an instruction
//   inst_out        : head instruction word
//   inst_pc         : PC of head instruction
//   inst_ready      : decoder consumes the head this cycle
//   dbg_state_o     : current fetch FSM state (0=IDLE, 1=WAIT, 2=DROP)
//
// Handshake: the head entry transfers on a rising edge where
//   inst_valid && inst_ready && !jump_valid. inst_valid never depends on
//   inst_ready; a jump in the same cycle cancels the transfer.
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        jump_valid,
  input  logic [31:0] jump_pc,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic [1:0]  dbg_state_o
);

  localparam int                 PTR_W    = $clog2(DEPTH);
  localparam int                 CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q;
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   count_q;
  logic               mem_req_valid_q;
  logic [31:0]        mem_req_addr_q;

  logic [31:0]        pc_mem   [DEPTH];
  logic [31:0]        word_mem [DEPTH];

  logic               full;
  logic               issue;
  logic               push;
  logic               pop;

  assign full = (count_q == FULL_CNT);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!jump_valid && !full) state_d = S_WAIT;
      end
      S_WAIT: begin
        // A response always closes the transaction, even if a jump discards it.
        if (mem_resp_valid)  state_d = S_IDLE;
        else if (jump_valid) state_d = S_DROP;
      end
      S_DROP: begin
        if (mem_resp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs / datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    issue = 1'b0;
    push  = 1'b0;
    case (state_q)
      S_IDLE:  issue = !jump_valid && !full;
      S_WAIT:  push  = mem_resp_valid && !jump_valid;
      default: ;
    endcase
    pop = inst_valid && inst_ready && !jump_valid;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc_q            <= RESET_PC;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
    end else begin
      mem_req_valid_q <= issue;
      if (issue) mem_req_addr_q <= pc_q;

      if (jump_valid) begin
        pc_q    <= jump_pc;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          pc_q   <= pc_q + 32'd4;
          tail_q <= tail_q + PTR_W'(1);
        end
        if (pop) head_q <= head_q + PTR_W'(1);
        // Room was reserved when the request issued, so a push never overflows.
        case ({push, pop})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Queue storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_in) begin
    if (push && !rst_in) begin
      pc_mem[tail_q]   <= pc_q;
      word_mem[tail_q] <= mem_resp_data;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign inst_valid    = (count_q != '0);
  assign inst_out      = word_mem[head_q];
  assign inst_pc       = pc_mem[head_q];
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Drives instr_fetch with a latency-programmable memory responder and a
//   randomised decoder, and compares every cycle against a transaction-level
//   model: an expected instruction queue, the expected next fetch address and
//   an outstanding/dropped flag for the single in-flight request.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int          DEPTH    = 8;
  localparam logic [31:0] RESET_PC = 32'h0;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        jump_valid;
  logic [31:0] jump_pc;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [1:0]  dbg_state_o;

  always #5 clk_in = ~clk_in;

  instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .jump_valid     (jump_valid),
    .jump_pc        (jump_pc),
    .inst_valid     (inst_valid),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .dbg_state_o    (dbg_state_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model state
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];      // expected instruction words, head first
  logic [31:0] exp_pc_q[$];   // matching PCs
  logic [31:0] m_pc;          // next address the fetcher must request
  logic        m_out;         // a request is in flight
  logic        m_drop;        // in-flight response must be discarded

  // Memory responder
  logic        mem_pend;
  int          mem_cnt;
  int          mem_lat;

  int          checks;
  int          failures;
  int          req_seen;
  int          pop_seen;
  int          max_size;
  logic [31:0] last_req_addr;

  // ---------------------------------------------------------------------------
  // One clock cycle: check outputs against the model, advance the model by the
  // rules for this edge, step the clock, then drive the memory response.
  // ---------------------------------------------------------------------------
  task automatic cycle();
    logic s_req;
    logic s_rst;
    s_req = (mem_req_valid === 1'b1);
    s_rst = rst_in;

    checks++;
    if (inst_valid !== (exp_q.size() != 0)) begin
      failures++;
      $display("FAIL inst_valid: got %b expected %b", inst_valid, exp_q.size() != 0);
    end
    if (exp_q.size() != 0 && inst_valid === 1'b1) begin
      checks++;
      if (inst_pc !== exp_pc_q[0] || inst_out !== exp_q[0]) begin
        failures++;
        $display("FAIL head_entry: got pc=%h word=%h expected pc=%h word=%h",
                 inst_pc, inst_out, exp_pc_q[0], exp_q[0]);
      end
    end

    if (s_req) begin
      req_seen++;
      last_req_addr = mem_req_addr;
      checks++;
      if (m_out) begin
        failures++;
        $display("FAIL second_outstanding: got request at %h expected none", mem_req_addr);
      end
      checks++;
      if (mem_req_addr !== m_pc) begin
        failures++;
        $display("FAIL req_addr: got %h expected %h", mem_req_addr, m_pc);
      end
      checks++;
      if (exp_q.size() >= DEPTH) begin
        failures++;
        $display("FAIL req_when_full: got request with %0d queued expected < %0d",
                 exp_q.size(), DEPTH);
      end
      m_out  = 1'b1;
      m_drop = 1'b0;
    end

    if (rst_in) begin
      exp_q.delete();
      exp_pc_q.delete();
      m_pc   = RESET_PC;
      m_out  = 1'b0;
      m_drop = 1'b0;
    end else begin
      if (exp_q.size() != 0 && inst_ready && !jump_valid) begin
        void'(exp_q.pop_front());
        void'(exp_pc_q.pop_front());
        pop_seen++;
      end
      if (mem_resp_valid && m_out) begin
        if (!jump_valid && !m_drop) begin
          exp_q.push_back(mem_resp_data);
          exp_pc_q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
        m_out  = 1'b0;
        m_drop = 1'b0;
      end
      if (jump_valid) begin
        exp_q.delete();
        exp_pc_q.delete();
        m_pc = jump_pc;
        if (m_out) m_drop = 1'b1;
      end
    end
    if (exp_q.size() > max_size) max_size = exp_q.size();

    @(posedge clk_in);
    #1;

    if (s_rst) begin
      mem_pend = 1'b0;
    end else begin
      if (mem_resp_valid) mem_pend = 1'b0;
      if (s_req) begin
        mem_pend = 1'b1;
        mem_cnt  = mem_lat;
      end
    end
    mem_resp_valid = 1'b0;
    mem_resp_data  = $urandom;
    if (mem_pend) begin
      if (mem_cnt > 0) mem_cnt--;
      if (mem_cnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = $urandom;
      end
    end
  endtask

  task automatic do_reset();
    rst_in     = 1'b1;
    jump_valid = 1'b0;
    inst_ready = 1'b0;
    cycle();
    cycle();
    rst_in = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_in     = 1'b1;
    jump_valid = 1'b1;
    jump_pc    = 32'h0000_0500;
    inst_ready = 1'b1;
    mem_lat    = 1;
    cycle();
    cycle();
    checks++;
    if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got req=%b addr=%h valid=%b expected 0 0 0",
               mem_req_valid, mem_req_addr, inst_valid);
    end
    rst_in     = 1'b0;
    jump_valid = 1'b0;
    cycle();
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC) begin
      failures++;
      $display("FAIL first_request: got req=%b addr=%h expected 1 %h",
               mem_req_valid, mem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int pops0;
    do_reset();
    mem_lat    = 1;
    inst_ready = 1'b1;
    pops0      = pop_seen;
    for (int i = 0; i < 60; i++) cycle();
    checks++;
    if (pop_seen - pops0 < 18) begin
      failures++;
      $display("FAIL stream_rate: got %0d instructions expected >= 18", pop_seen - pops0);
    end
  endtask

  task automatic test_full();
    int reqs0;
    do_reset();
    mem_lat    = 1;
    inst_ready = 1'b0;
    reqs0      = req_seen;
    for (int i = 0; i < 40; i++) cycle();
    checks++;
    if (req_seen - reqs0 != DEPTH || mem_req_valid !== 1'b0 || inst_valid !== 1'b1) begin
      failures++;
      $display("FAIL fill_stop: got reqs=%0d req=%b valid=%b expected %0d 0 1",
               req_seen - reqs0, mem_req_valid, inst_valid, DEPTH);
    end
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    checks++;
    if (req_seen - reqs0 != DEPTH + 1 || last_req_addr !== 32'h20) begin
      failures++;
      $display("FAIL refill_one: got reqs=%0d addr=%h expected %0d 00000020",
               req_seen - reqs0, last_req_addr, DEPTH + 1);
    end
    checks++;
    if (inst_pc !== 32'h4) begin
      failures++;
      $display("FAIL head_after_pop: got %h expected 00000004", inst_pc);
    end
  endtask

  task automatic test_jump_wait();
    bit found;
    do_reset();
    mem_lat    = 3;
    inst_ready = 1'b0;
    found      = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_req_valid === 1'b1 && mem_req_addr === 32'h8) found = 1'b1;
      else cycle();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL jw_wait_req: got no request at 00000008 expected one");
    end
    cycle();
    jump_valid = 1'b1;
    jump_pc    = 32'h100;
    cycle();
    jump_valid = 1'b0;
    found      = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_req_valid === 1'b1) found = 1'b1;
      else cycle();
    end
    checks++;
    if (!found || mem_req_addr !== 32'h100 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL jw_redirect: got found=%b addr=%h valid=%b expected 1 00000100 0",
               found, mem_req_addr, inst_valid);
    end
    cycle();
  endtask

  task automatic test_jump_coincident();
    bit          found;
    logic [31:0] jpc;
    do_reset();
    mem_lat    = 2;
    inst_ready = 1'b0;
    for (int i = 0; i < 15; i++) cycle();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_resp_valid === 1'b1) found = 1'b1;
      else cycle();
    end
    checks++;
    if (!found || inst_valid !== 1'b1) begin
      failures++;
      $display("FAIL jc_setup: got resp=%b valid=%b expected 1 1", found, inst_valid);
    end
    jpc        = {$urandom_range(16'h1000, 16'hffff), 16'h0} | 32'h40;
    jump_valid = 1'b1;
    jump_pc    = jpc;
    inst_ready = 1'b1;
    cycle();
    jump_valid = 1'b0;
    inst_ready = 1'b0;
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL jc_flush: got valid=%b expected 0", inst_valid);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_req_valid === 1'b1) found = 1'b1;
      else cycle();
    end
    checks++;
    if (!found || mem_req_addr !== jpc) begin
      failures++;
      $display("FAIL jc_redirect: got found=%b addr=%h expected 1 %h", found, mem_req_addr, jpc);
    end
    cycle();
  endtask

  task automatic test_random();
    int pops0;
    do_reset();
    pops0    = pop_seen;
    max_size = 0;
    for (int i = 0; i < 800 && (pop_seen - pops0) < 20; i++) begin
      mem_lat    = $urandom_range(1, 3);
      inst_ready = ($urandom_range(0, 99) < 35);
      cycle();
    end
    checks++;
    if (pop_seen - pops0 < 20) begin
      failures++;
      $display("FAIL rand_drain: got %0d instructions expected >= 20", pop_seen - pops0);
    end
    checks++;
    if (max_size > DEPTH) begin
      failures++;
      $display("FAIL rand_occupancy: got %0d expected <= %0d", max_size, DEPTH);
    end
    // Mixed phase with occasional redirects.
    for (int i = 0; i < 400; i++) begin
      mem_lat    = $urandom_range(1, 4);
      inst_ready = ($urandom_range(0, 99) < 50);
      jump_valid = ($urandom_range(0, 99) < 5);
      jump_pc    = $urandom & 32'hffff_fffc;
      cycle();
    end
    jump_valid = 1'b0;
    cycle();
  endtask

  task automatic test_reset_mid_wait();
    bit found;
    do_reset();
    mem_lat    = 4;
    inst_ready = 1'b0;
    found      = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (mem_req_valid === 1'b1 && exp_q.size() == 3) found = 1'b1;
      else cycle();
    end
    checks++;
    if (!found || inst_valid !== 1'b1) begin
      failures++;
      $display("FAIL rw_setup: got found=%b valid=%b expected 1 1", found, inst_valid);
    end
    cycle();
    rst_in = 1'b1;
    cycle();
    checks++;
    if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL rw_reset: got valid=%b req=%b expected 0 0", inst_valid, mem_req_valid);
    end
    rst_in = 1'b0;
    cycle();
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC) begin
      failures++;
      $display("FAIL rw_first_req: got req=%b addr=%h expected 1 %h",
               mem_req_valid, mem_req_addr, RESET_PC);
    end
    cycle();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    checks         = 0;
    failures       = 0;
    req_seen       = 0;
    pop_seen       = 0;
    max_size       = 0;
    last_req_addr  = '0;
    m_pc           = RESET_PC;
    m_out          = 1'b0;
    m_drop         = 1'b0;
    mem_pend       = 1'b0;
    mem_cnt        = 0;
    mem_lat        = 1;
    rst_in         = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    jump_valid     = 1'b0;
    jump_pc        = '0;
    inst_ready     = 1'b0;
    @(posedge clk_in);
    #1;

    test_reset();
    test_stream();
    test_full();
    test_jump_wait();
    test_jump_coincident();
    test_random();
    test_reset_mid_wait();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
